// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between instruction fetch and data access.
// Screens data requests for misalignment and illegal funct3 before they reach
// memory. A starvation counter guarantees that fetch eventually gets the port.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W     = 8,
    parameter int unsigned MAX_STREAK = 3
) (
    input  logic              clk,
    input  logic              rst,
    // instruction fetch requester
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ready,
    output logic [31:0]       if_rdata,
    output logic              if_rvalid,
    // data requester
    input  logic              d_req,
    input  logic              d_we,
    input  logic [2:0]        d_f3,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    output logic              d_ready,
    output logic [31:0]       d_rdata,
    output logic              d_rvalid,
    output logic              d_fault,
    // memory port
    output logic              mem_read,
    output logic              mem_write,
    output logic [2:0]        mem_f3,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    localparam logic [3:0] MaxStreak = 4'(MAX_STREAK);

    logic        d_legal;
    logic        d_faulting;
    logic        starved;
    logic        grant_d;
    logic        grant_if;
    logic [3:0]  streak_q, streak_d;
    logic [31:0] if_rdata_q, d_rdata_q;
    logic        if_rvalid_q, d_rvalid_q, d_fault_q;

    // Legality of the presented data request: funct3 class plus natural alignment.
    always_comb begin
        d_legal = 1'b0;
        unique case (d_f3)
            3'b000:  d_legal = 1'b1;
            3'b001:  d_legal = ~d_addr[0];
            3'b010:  d_legal = (d_addr[1:0] == 2'b00);
            3'b100:  d_legal = ~d_we;
            3'b101:  d_legal = ~d_we & ~d_addr[0];
            default: d_legal = 1'b0;
        endcase
    end

    // Grant selection: a faulting data request is consumed without using the port,
    // so fetch may take it in the same cycle.
    always_comb begin
        d_faulting = d_req & ~d_legal;
        starved    = if_req & (streak_q == MaxStreak);
        grant_d    = d_req & ~d_faulting & ~starved;
        grant_if   = if_req & ~grant_d;
        if_ready   = grant_if;
        d_ready    = d_faulting | grant_d;
    end

    // Memory port drive from the granted requester; idle port is all zeros.
    always_comb begin
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_f3    = 3'b000;
        mem_addr  = '0;
        mem_wdata = 32'h0;
        if (grant_d) begin
            mem_f3   = d_f3;
            mem_addr = d_addr;
            if (d_we) begin
                mem_write = 1'b1;
                mem_wdata = d_wdata;
            end else begin
                mem_read = 1'b1;
            end
        end else if (grant_if) begin
            mem_read = 1'b1;
            mem_f3   = 3'b010;
            mem_addr = if_addr;
        end
    end

    // Starvation counter next state: counts denied fetch cycles, saturating.
    always_comb begin
        streak_d = streak_q;
        if (!if_req || grant_if) begin
            streak_d = 4'd0;
        end else if (streak_q < MaxStreak) begin
            streak_d = streak_q + 4'd1;
        end
    end

    // Starvation counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            streak_q <= 4'd0;
        end else begin
            streak_q <= streak_d;
        end
    end

    // Response pulses: one cycle after the granting (or faulting) edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            if_rvalid_q <= 1'b0;
            d_rvalid_q  <= 1'b0;
            d_fault_q   <= 1'b0;
        end else begin
            if_rvalid_q <= grant_if;
            d_rvalid_q  <= grant_d & ~d_we;
            d_fault_q   <= d_faulting;
        end
    end

    // Read data capture at the grant edge; held until the next capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            if_rdata_q <= 32'h0;
            d_rdata_q  <= 32'h0;
        end else begin
            if (grant_if) begin
                if_rdata_q <= mem_rdata;
            end
            if (grant_d && !d_we) begin
                d_rdata_q <= mem_rdata;
            end
        end
    end

    assign if_rdata  = if_rdata_q;
    assign if_rvalid = if_rvalid_q;
    assign d_rdata   = d_rdata_q;
    assign d_rvalid  = d_rvalid_q;
    assign d_fault   = d_fault_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter with a word memory model.
module tb_mem_port_arbiter;

    localparam int unsigned ADDR_W = 8;

    logic              clk, rst;
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_ready;
    logic [31:0]       if_rdata;
    logic              if_rvalid;
    logic              d_req, d_we;
    logic [2:0]        d_f3;
    logic [ADDR_W-1:0] d_addr;
    logic [31:0]       d_wdata;
    logic              d_ready;
    logic [31:0]       d_rdata;
    logic              d_rvalid, d_fault;
    logic              mem_read, mem_write;
    logic [2:0]        mem_f3;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    logic [31:0] mem_w [64];

    int n_checks = 0;
    int n_fail   = 0;

    mem_port_arbiter #(.ADDR_W(ADDR_W), .MAX_STREAK(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_ready  (if_ready),
        .if_rdata  (if_rdata),
        .if_rvalid (if_rvalid),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_f3      (d_f3),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_ready   (d_ready),
        .d_rdata   (d_rdata),
        .d_rvalid  (d_rvalid),
        .d_fault   (d_fault),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_f3    (mem_f3),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Combinational-read word memory; word stores commit at the rising edge.
    assign mem_rdata = mem_w[mem_addr[7:2]];
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 64; i++) mem_w[i] <= 32'h0;
            mem_w[0]  <= 32'd17;
            mem_w[9]  <= 32'h0000_2083;
            mem_w[10] <= 32'h0000_1111;
            mem_w[11] <= 32'h0000_AAAA;
        end else if (mem_write && mem_f3 == 3'b010) begin
            mem_w[mem_addr[7:2]] <= mem_wdata;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        if_req = 1'b0; if_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_f3 = 3'b000; d_addr = '0; d_wdata = 32'h0;
    endtask

    task automatic data_req(input logic we, input logic [2:0] f3, input logic [7:0] a,
                            input logic [31:0] wd);
        d_req = 1'b1; d_we = we; d_f3 = f3; d_addr = a; d_wdata = wd;
    endtask

    logic exp_d [5];
    logic exp_i [5];

    initial begin
        idle();
        rst = 1'b1;
        tick();
        tick();
        check("rst_if_rdata", if_rdata, 32'h0);
        check("rst_d_rdata", d_rdata, 32'h0);
        check("rst_pulses", {29'h0, if_rvalid, d_rvalid, d_fault}, 32'h0);
        rst = 1'b0;
        tick();
        check("idle_port", {20'h0, mem_read, mem_write, mem_f3, mem_addr}, 32'h0);

        // Fetch only.
        if_req = 1'b1; if_addr = 8'd36;
        #1;
        check("f_ready", {31'h0, if_ready}, 32'd1);
        check("f_port", {20'h0, mem_read, mem_write, mem_f3, mem_addr}, {20'h0, 2'b10, 3'b010, 8'd36});
        tick();
        idle();
        check("f_rvalid", {31'h0, if_rvalid}, 32'd1);
        check("f_rdata", if_rdata, 32'h0000_2083);
        tick();
        check("f_rvalid_drop", {31'h0, if_rvalid}, 32'd0);

        // Simultaneous data load and fetch: data wins.
        data_req(1'b0, 3'b010, 8'd0, 32'h0);
        if_req = 1'b1; if_addr = 8'd40;
        #1;
        check("sim_ready", {30'h0, d_ready, if_ready}, 32'b10);
        tick();
        d_req = 1'b0;
        #1;
        check("sim_d_rvalid", {31'h0, d_rvalid}, 32'd1);
        check("sim_d_rdata", d_rdata, 32'd17);
        check("sim_f_ready", {31'h0, if_ready}, 32'd1);
        tick();
        idle();
        check("sim_f_rdata", if_rdata, 32'h0000_1111);
        tick();

        // Starvation: three data grants, then one forced fetch, then data again.
        exp_d = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        exp_i = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        data_req(1'b0, 3'b010, 8'd0, 32'h0);
        if_req = 1'b1; if_addr = 8'd44;
        for (int c = 0; c < 5; c++) begin
            #1;
            check($sformatf("starve_c%0d", c), {30'h0, d_ready, if_ready},
                  {30'h0, exp_d[c], exp_i[c]});
            tick();
        end
        idle();
        tick();

        // Store then load back.
        data_req(1'b1, 3'b010, 8'd12, 32'd42);
        #1;
        check("sw_port", {27'h0, d_ready, mem_read, mem_write, mem_f3 == 3'b010, 1'b0},
              {27'h0, 5'b10110});
        check("sw_wdata", mem_wdata, 32'd42);
        tick();
        data_req(1'b0, 3'b010, 8'd12, 32'h0);
        #1;
        check("sw_no_rvalid", {31'h0, d_rvalid}, 32'd0);
        check("lw_no_write", {30'h0, mem_write, mem_read}, 32'b01);
        tick();
        idle();
        check("lw_rdata", d_rdata, 32'd42);
        check("lw_rvalid", {31'h0, d_rvalid}, 32'd1);
        tick();

        // Misaligned LW with concurrent fetch: fetch takes the port.
        data_req(1'b0, 3'b010, 8'd6, 32'h0);
        if_req = 1'b1; if_addr = 8'd44;
        #1;
        check("mis_ready", {30'h0, d_ready, if_ready}, 32'b11);
        check("mis_port", {20'h0, mem_read, mem_write, mem_f3, mem_addr}, {20'h0, 2'b10, 3'b010, 8'd44});
        tick();
        idle();
        check("mis_pulses", {29'h0, d_fault, d_rvalid, if_rvalid}, 32'b101);
        check("mis_f_rdata", if_rdata, 32'h0000_AAAA);
        // Misaligned LH.
        data_req(1'b0, 3'b001, 8'd5, 32'h0);
        #1;
        check("lh_port", {30'h0, d_ready, mem_read}, 32'b10);
        tick();
        // Illegal load funct3.
        data_req(1'b0, 3'b011, 8'd0, 32'h0);
        #1;
        check("lh_fault", {31'h0, d_fault}, 32'd1);
        tick();
        // Illegal store funct3 (LBU encoding as store).
        data_req(1'b1, 3'b100, 8'd0, 32'hDEAD_BEEF);
        #1;
        check("f3_fault", {31'h0, d_fault}, 32'd1);
        check("sb_illegal_port", {30'h0, d_ready, mem_write}, 32'b10);
        tick();
        idle();
        check("sb_fault", {30'h0, d_fault, d_rvalid}, 32'b10);
        tick();
        check("fault_drop", {31'h0, d_fault}, 32'd0);

        // Reset right after a load grant.
        data_req(1'b0, 3'b010, 8'd0, 32'h0);
        if_req = 1'b1; if_addr = 8'd40;
        tick();
        idle();
        check("pre_rst_rvalid", {31'h0, d_rvalid}, 32'd1);
        check("pre_rst_streak", {28'h0, dut.streak_q}, 32'd1);
        rst = 1'b1;
        #1;
        check("rst_mid_pulses", {30'h0, d_rvalid, d_fault}, 32'd0);
        check("rst_mid_rdata", d_rdata, 32'h0);
        check("rst_mid_streak", {28'h0, dut.streak_q}, 32'd0);
        tick();
        rst = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Sits directly upstream of the unified byte-addressed instruction/data memory. Owns that memory's single port.
- Arbitrates each cycle between the instruction-fetch requester (IF stage) and the data requester (MEM stage).
- Drives the memory's read/write controls, address, funct3 and write data. Registers returned read data per requester.
- Detects misaligned or illegal data accesses before they reach memory, and guarantees fetch forward progress with a starvation counter.

Parameters:
- ADDR_W, 8, byte-address width presented to memory.
- MAX_STREAK, 3, consecutive denied fetch cycles after which fetch wins priority for one cycle (legal range 1..15).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- if_req  in  1  fetch request, held until if_ready.
- if_addr  in  ADDR_W  fetch byte address.
- if_ready  out  1  fetch granted this cycle (combinational).
- if_rdata  out  32  registered fetched word.
- if_rvalid  out  1  if_rdata valid; one-cycle pulse.
- d_req  in  1  data request, held until d_ready.
- d_we  in  1  1 = store, 0 = load.
- d_f3  in  3  load/store funct3.
- d_addr  in  ADDR_W  data byte address.
- d_wdata  in  32  store data.
- d_ready  out  1  data request consumed this cycle (combinational).
- d_rdata  out  32  registered load result.
- d_rvalid  out  1  d_rdata valid; one-cycle pulse, loads only.
- d_fault  out  1  one-cycle pulse: previous data request was misaligned or had illegal funct3.
- mem_read  out  1  memory read enable.
- mem_write  out  1  memory write enable.
- mem_f3  out  3  memory funct3.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  32  memory write data.
- mem_rdata  in  32  memory combinational read data.

Behaviour:
- Interface: one clock; reset is asynchronous and active-high (clk, rst).
- Reset values: if_rdata, d_rdata = 0; if_rvalid, d_rvalid, d_fault = 0; streak counter = 0.
- Reset asserted mid-operation discards any pending rvalid/fault pulse.
- Port drive is combinational from the granted requester. When there is no grant: mem_read = mem_write = 0, mem_addr = 0, mem_f3 = 0, mem_wdata = 0.

Data request legality:
- Legal loads: f3 in {000, 001, 010, 100, 101}.
- Legal stores: f3 in {000, 001, 010}.
- Halfword (001/101) requires addr[0] = 0. Word (010) requires addr[1:0] = 00.
- Any violation makes the request faulting.

Grant rules, evaluated each cycle:
1. d_req and faulting:
   - d_ready = 1 and memory is not touched.
   - d_fault = 1 next cycle; d_rvalid stays 0.
   - The port is free that cycle, so a concurrent if_req is granted.
2. Else, d_req, if_req and streak == MAX_STREAK: fetch granted, d_ready = 0.
3. Else, d_req: data granted; if_ready = 0.
4. Else, if_req: fetch granted.

Port drive:
- Fetch grant: mem_read = 1, mem_f3 = 010, mem_addr = if_addr.
- Data load grant: mem_read = 1, mem_f3 = d_f3.
- Data store grant: mem_write = 1, mem_f3 = d_f3, mem_wdata = d_wdata. The write commits at the same rising edge.

Read latency:
- mem_rdata is captured at the grant edge into if_rdata or d_rdata.
- The matching rvalid is high the following cycle only. The rdata register holds its value until the next capture.

Streak counter:
- Increments on each cycle where if_req = 1 and if_ready = 0, saturating at MAX_STREAK.
- Clears on a fetch grant or when if_req = 0.

Other rules:
- Stores never assert d_rvalid.
- if_addr[1:0] is not checked; alignment is the fetch unit's responsibility.

Test Plan:
- Reset, then fetch-only if_req, if_addr = 36 with memory word 0x00002083 at 36 -> if_ready = 1 same cycle; next cycle if_rvalid = 1, if_rdata = 0x00002083; if_rvalid = 0 the cycle after.
- Simultaneous d_req LW addr 0 (word 17) and if_req addr 40 -> d_ready = 1, if_ready = 0; next cycle d_rvalid = 1, d_rdata = 17; fetch granted the following cycle.
- d_req held with back-to-back LW and if_req held, MAX_STREAK = 3 -> data granted 3 cycles; 4th cycle if_ready = 1, d_ready = 0; streak clears; data granted again on the 5th cycle.
- d_req SW addr 12 data 42 (mem model stores 42), then LW addr 12 -> mem_write pulses once with mem_f3 = 010; the load returns d_rdata = 42; d_rvalid = 0 after the store.
- d_req LW addr 6 with concurrent if_req addr 44 -> mem_read driven by fetch only; next cycle d_fault = 1, d_rvalid = 0, if_rvalid = 1. Repeat with LH addr 5 and with illegal load f3 = 011 -> d_fault = 1 in both cases.
- Assert rst in the cycle after a load grant -> d_rvalid and d_fault forced 0 immediately; d_rdata = 0; counter = 0.
